uart_tx_buffered: RTL and testbench

Buffered UART transmitter: accepts bytes over a valid/ready write port into an 8-entry FIFO, then serializes them 8N1, LSB first, on o_Tx_Serial.
It is the transmit end of the team's UART link and drives the line a host-side receiver samples.
It sits beside uart_rx in uart_loopback_top and replaces the unbuffered transmitter, so back-to-back echo bytes are never lost while a frame is in flight.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_buffered_if.sv | 29 ++
 rtl/uart_sync_fifo.sv | 53 +++++
 rtl/uart_tx_buffered.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Optional build macro: UART_TX_PARITY_EN (adds the PARITY state).
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int CLKS_PER_BIT_DEF = 87;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        PARITY
    } tx_state_t;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Write port and line/status signals of the buffered UART transmitter.
// master drives bytes in; slave is the transmitter itself.
interface uart_tx_buffered_if #(
    parameter int FIFO_DEPTH = 8
) ();
    import uart_pkg::*;

    logic                        i_Tx_DV;
    logic [DATA_BITS-1:0]        i_Tx_Byte;
    logic                        o_Tx_Ready;
    logic                        o_Tx_Serial;
    logic                        o_Tx_Active;
    logic                        o_Tx_Done;
    logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count;
    logic                        o_Overflow;

    modport master (
        output i_Tx_DV, i_Tx_Byte,
        input  o_Tx_Ready, o_Tx_Serial, o_Tx_Active,
        input  o_Tx_Done, o_Fifo_Count, o_Overflow
    );

    modport slave (
        input  i_Tx_DV, i_Tx_Byte,
        output o_Tx_Ready, o_Tx_Serial, o_Tx_Active,
        output o_Tx_Done, o_Fifo_Count, o_Overflow
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two.
// Pointers wrap naturally; a same-cycle write and read keep the count.
module uart_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter, LSB first, fed from a small FIFO.
// Optional build macro: UART_TX_PARITY_EN (even parity bit before STOP).
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic               i_Clock,
    input  logic               i_Reset,
    uart_tx_buffered_if.slave  tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int NW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t            state;
    logic [CW-1:0]        clk_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 serial;
    logic                 active;
    logic                 done;
    logic                 overflow;
`ifdef UART_TX_PARITY_EN
    logic                 par_bit;
`endif

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;
    logic [NW-1:0]        fifo_count;
    logic                 ready;
    logic                 accept;
    logic                 pop;
    logic                 bit_end;

    assign ready   = !fifo_full;
    assign accept  = tx.i_Tx_DV && ready;
    assign pop     = (state == IDLE) && !fifo_empty;
    assign bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (i_Clock),
        .rst     (i_Reset),
        .wr_en   (accept),
        .wr_data (tx.i_Tx_Byte),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Flag a write strobe that arrives while the FIFO is full.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) overflow <= 1'b0;
        else         overflow <= tx.i_Tx_DV && !ready;
    end

    // Serializer: one frame per popped byte, registered line outputs.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            serial  <= 1'b1;
            active  <= 1'b0;
            done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    serial  <= 1'b1;
                    active  <= 1'b0;
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (!fifo_empty) begin
                        shift  <= fifo_data;
                        state  <= START;
                        serial <= 1'b0;
                        active <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        par_bit <= ^fifo_data;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        state   <= DATA;
                        serial  <= shift[0];
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        shift   <= shift >> 1;
                        if (bit_idx == BW'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            state  <= PARITY;
                            serial <= par_bit;
`else
                            state  <= STOP;
                            serial <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            serial  <= shift[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                PARITY: begin
`ifdef UART_TX_PARITY_EN
                    if (bit_end) begin
                        clk_cnt <= '0;
                        state   <= STOP;
                        serial  <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
`else
                    state <= IDLE;
`endif
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        active  <= 1'b0;
                        serial  <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                        done    <= (clk_cnt == CW'(CLKS_PER_BIT - 2));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx.o_Tx_Ready   = ready;
    assign tx.o_Tx_Serial  = serial;
    assign tx.o_Tx_Active  = active;
    assign tx.o_Tx_Done    = done;
    assign tx.o_Fifo_Count = fifo_count;
    assign tx.o_Overflow   = overflow;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed self-checking bench for uart_tx_buffered.
// Build with UART_TX_PARITY_EN to cover the parity frame.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

    localparam int C = 87;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    uart_tx_buffered_if #(.FIFO_DEPTH(8)) bus ();

    uart_tx_buffered #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (8)
    ) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .tx      (bus)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        bus.i_Tx_DV   = 1'b1;
        bus.i_Tx_Byte = b;
    endtask

    task automatic idle();
        bus.i_Tx_DV = 1'b0;
    endtask

    // Line monitor: decodes frames at mid-bit
    logic [7:0] rxq [$];
    logic       pq  [$];
    logic       mon_en  = 1'b0;
    int         rst_gen = 0;
    logic [7:0] m_d;
    logic       m_bad, m_stop, m_par;
    int         m_g;

    initial begin
        m_par = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && bus.o_Tx_Serial === 1'b0) begin
                m_g = rst_gen;
                repeat (C/2) @(negedge clk);
                m_bad = (bus.o_Tx_Serial !== 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    m_d[i] = bus.o_Tx_Serial;
                end
`ifdef UART_TX_PARITY_EN
                repeat (C) @(negedge clk);
                m_par = bus.o_Tx_Serial;
`endif
                repeat (C) @(negedge clk);
                m_stop = bus.o_Tx_Serial;
                if (m_g == rst_gen) begin
                    chk("mon_start", m_bad, 0);
                    chk("mon_stop", m_stop, 1);
`ifdef UART_TX_PARITY_EN
                    chk("mon_parity", m_par, ^m_d);
`endif
                    rxq.push_back(m_d);
                    pq.push_back(m_par);
                end
            end
        end
    end

    int n, falls, gaplen, maxc, bad;
    logic prev;
    int gaps [$];

    initial begin
        rst = 1'b0;
        bus.i_Tx_DV   = 1'b0;
        bus.i_Tx_Byte = 8'h00;
        #5 rst = 1'b1;
        step();
        step();
        chk("rst_serial", bus.o_Tx_Serial, 1);
        chk("rst_active", bus.o_Tx_Active, 0);
        chk("rst_done",   bus.o_Tx_Done, 0);
        chk("rst_ovf",    bus.o_Overflow, 0);
        chk("rst_ready",  bus.o_Tx_Ready, 1);
        chk("rst_count",  bus.o_Fifo_Count, 0);
        @(negedge clk) rst = 1'b0;
        step();
        mon_en = 1'b1;

        // single byte 0x41: latency and frame length
        put(8'h41);
        step();
        idle();
        chk("t1_count",   bus.o_Fifo_Count, 1);
        chk("t1_pre_ser", bus.o_Tx_Serial, 1);
        step();
        chk("t1_start",   bus.o_Tx_Serial, 0);
        chk("t1_active",  bus.o_Tx_Active, 1);
        chk("t1_popped",  bus.o_Fifo_Count, 0);
        n = 0;
        while (n < 2000 && bus.o_Tx_Done !== 1'b1) begin
            step();
            n++;
        end
        chk("t1_done_at", n, FB*C - 1);
        step();
        chk("t1_done_1clk", bus.o_Tx_Done, 0);
        chk("t1_end_act",   bus.o_Tx_Active, 0);
        chk("t1_end_ser",   bus.o_Tx_Serial, 1);
        chk("t1_rx_n", rxq.size(), 1);
        if (rxq.size() > 0) chk("t1_rx", rxq[0], 8'h41);
        rxq.delete();
        pq.delete();

        // four back-to-back bytes
        maxc = 0;
        for (int i = 0; i < 4; i++) begin
            put(8'h41 + 8'(i));
            step();
            if (int'(bus.o_Fifo_Count) > maxc) maxc = int'(bus.o_Fifo_Count);
        end
        idle();
        prev = bus.o_Tx_Active;
        falls = 0;
        gaplen = 0;
        n = 0;
        while (falls < 4 && n < 5000) begin
            step();
            n++;
            if (int'(bus.o_Fifo_Count) > maxc) maxc = int'(bus.o_Fifo_Count);
            if (prev && !bus.o_Tx_Active) begin
                falls++;
                gaplen = 0;
            end
            if (!bus.o_Tx_Active) gaplen++;
            if (!prev && bus.o_Tx_Active) gaps.push_back(gaplen);
            prev = bus.o_Tx_Active;
        end
        chk("t2_frames", falls, 4);
        chk("t2_gaps_n", gaps.size(), 3);
        foreach (gaps[i]) chk("t2_gap", gaps[i], 1);
        chk("t2_maxcnt", maxc, 3);
        chk("t2_rx_n", rxq.size(), 4);
        foreach (rxq[i]) chk("t2_rx", rxq[i], 8'h41 + 8'(i));
        rxq.delete();
        pq.delete();

        // fill while transmitting, then overflow
        for (int i = 0; i < 9; i++) begin
            put(8'h10 + 8'(i));
            step();
        end
        chk("t3_count",  bus.o_Fifo_Count, 8);
        chk("t3_ready",  bus.o_Tx_Ready, 0);
        chk("t3_no_ovf", bus.o_Overflow, 0);
        put(8'h99);
        step();
        idle();
        chk("t3_ovf",     bus.o_Overflow, 1);
        chk("t3_count2",  bus.o_Fifo_Count, 8);
        step();
        chk("t3_ovf_1clk", bus.o_Overflow, 0);

        // write while full during the pop cycle
        n = 0;
        while (bus.o_Tx_Active && n < 2000) begin
            step();
            n++;
        end
        chk("t5_idle",  bus.o_Tx_Active, 0);
        chk("t5_full",  bus.o_Fifo_Count, 8);
        chk("t5_ready0", bus.o_Tx_Ready, 0);
        put(8'hEE);
        step();
        idle();
        chk("t5_ovf",   bus.o_Overflow, 1);
        chk("t5_count", bus.o_Fifo_Count, 7);
        chk("t5_ready", bus.o_Tx_Ready, 1);
        n = 0;
        while ((bus.o_Fifo_Count != 0 || bus.o_Tx_Active) && n < 12000) begin
            step();
            n++;
        end
        repeat (4) step();
        chk("t3_rx_n", rxq.size(), 9);
        foreach (rxq[i]) chk("t3_rx", rxq[i], 8'h10 + 8'(i));
        rxq.delete();
        pq.delete();

        // reset in DATA bit 3 of 0x55 with two queued
        put(8'h55);
        step();
        put(8'hA1);
        step();
        put(8'hA2);
        step();
        idle();
        repeat (4*C + C/2) step();
        chk("t4_queued", bus.o_Fifo_Count, 2);
        chk("t4_bit3",   bus.o_Tx_Serial, 0);
        #10 rst = 1'b1;
        rst_gen++;
        #1;
        chk("t4_ser",   bus.o_Tx_Serial, 1);
        chk("t4_act",   bus.o_Tx_Active, 0);
        chk("t4_count", bus.o_Fifo_Count, 0);
        chk("t4_ready", bus.o_Tx_Ready, 1);
        chk("t4_done",  bus.o_Tx_Done, 0);
        step();
        @(negedge clk) rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 1500; i++) begin
            step();
            if (bus.o_Tx_Serial !== 1'b1 || bus.o_Tx_Active !== 1'b0 ||
                bus.o_Tx_Done !== 1'b0)
                bad++;
        end
        chk("t4_idle", bad, 0);
        chk("t4_rx_n", rxq.size(), 0);

`ifdef UART_TX_PARITY_EN
        // parity frames
        put(8'h07);
        step();
        idle();
        step();
        n = 0;
        while (n < 2000 && bus.o_Tx_Done !== 1'b1) begin
            step();
            n++;
        end
        chk("t6_done_at", n, 956);
        repeat (3) step();
        put(8'h03);
        step();
        idle();
        n = 0;
        while (n < 2000 && rxq.size() < 2) begin
            step();
            n++;
        end
        chk("t6_rx_n", rxq.size(), 2);
        if (rxq.size() == 2) begin
            chk("t6_rx0", rxq[0], 8'h07);
            chk("t6_par0", pq[0], 1);
            chk("t6_rx1", rxq[1], 8'h03);
            chk("t6_par1", pq[1], 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
